// File: rtl/effect_arbiter_if.sv
// ----------------------------------------------------------------------------
// effect_arbiter_if
// Bundles the channel-side and effect-side signals of effect_arbiter.
//   Channel inputs : i_l_valid/i_l_data, i_r_valid/i_r_data
//   Channel accepts: o_l_ready, o_r_ready (combinational in the arbiter)
//   Effect side    : o_eff_data/o_eff_valid out, i_eff_ready/i_eff_data/i_eff_valid in
//   Results        : o_l_data/o_l_valid, o_r_data/o_r_valid
//   Status         : o_busy, o_timeout
// slave  = the arbiter's view, master = the surrounding logic's view.
// ----------------------------------------------------------------------------
interface effect_arbiter_if #(
    parameter int unsigned d_width = 16
) ();
    logic               i_l_valid;
    logic [d_width-1:0] i_l_data;
    logic               o_l_ready;
    logic               i_r_valid;
    logic [d_width-1:0] i_r_data;
    logic               o_r_ready;
    logic [d_width-1:0] o_eff_data;
    logic               o_eff_valid;
    logic               i_eff_ready;
    logic [d_width-1:0] i_eff_data;
    logic               i_eff_valid;
    logic [d_width-1:0] o_l_data;
    logic               o_l_valid;
    logic [d_width-1:0] o_r_data;
    logic               o_r_valid;
    logic               o_busy;
    logic               o_timeout;

    modport slave (
        input  i_l_valid, i_l_data, i_r_valid, i_r_data,
        input  i_eff_ready, i_eff_data, i_eff_valid,
        output o_l_ready, o_r_ready, o_eff_data, o_eff_valid,
        output o_l_data, o_l_valid, o_r_data, o_r_valid, o_busy, o_timeout
    );

    modport master (
        output i_l_valid, i_l_data, i_r_valid, i_r_data,
        output i_eff_ready, i_eff_data, i_eff_valid,
        input  o_l_ready, o_r_ready, o_eff_data, o_eff_valid,
        input  o_l_data, o_l_valid, o_r_data, o_r_valid, o_busy, o_timeout
    );
endinterface

// File: rtl/effect_arbiter.sv
// ----------------------------------------------------------------------------
// effect_arbiter
// Shares one effect pipeline between left and right audio channels. Grants one
// channel at a time (round-robin on contention), issues the held sample to the
// effect, waits for the processed result and routes it back to the owner. If
// the effect stays silent for timeout_cycles WAIT cycles, the dry sample is
// returned instead and the sticky o_timeout flag is raised.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - effect_arbiter_if.slave (channel handshakes, effect side, results,
//           status); o_l_ready/o_r_ready are combinational, all else registered
// ----------------------------------------------------------------------------
module effect_arbiter #(
    parameter int unsigned d_width        = 16,
    parameter int unsigned timeout_cycles = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    effect_arbiter_if.slave      bus
);
    localparam int unsigned cnt_width = $clog2(timeout_cycles + 1);
    localparam logic [cnt_width-1:0] cnt_last = cnt_width'(timeout_cycles - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } ch_t;

    state_t               state_q,      state_d;
    ch_t                  last_grant_q, last_grant_d;
    ch_t                  hold_ch_q,    hold_ch_d;
    logic [d_width-1:0]   hold_data_q,  hold_data_d;
    logic [cnt_width-1:0] cnt_q,        cnt_d;
    logic                 eff_valid_q,  eff_valid_d;
    logic [d_width-1:0]   eff_data_q,   eff_data_d;
    logic [d_width-1:0]   l_data_q,     l_data_d;
    logic                 l_valid_q,    l_valid_d;
    logic [d_width-1:0]   r_data_q,     r_data_d;
    logic                 r_valid_q,    r_valid_d;
    logic                 busy_q,       busy_d;
    logic                 timeout_q,    timeout_d;

    logic                 grant_l_c;
    logic                 grant_r_c;
    logic                 finish_c;
    logic [d_width-1:0]   result_c;

    // Round-robin grant: only in IDLE; on contention the channel that did not go last wins.
    always_comb begin
        grant_l_c = 1'b0;
        grant_r_c = 1'b0;
        if (state_q == S_IDLE) begin
            if (bus.i_l_valid && bus.i_r_valid) begin
                if (last_grant_q == CH_R) begin
                    grant_l_c = 1'b1;
                end else begin
                    grant_r_c = 1'b1;
                end
            end else if (bus.i_l_valid) begin
                grant_l_c = 1'b1;
            end else if (bus.i_r_valid) begin
                grant_r_c = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        hold_ch_d    = hold_ch_q;
        hold_data_d  = hold_data_q;
        cnt_d        = cnt_q;
        eff_valid_d  = 1'b0;
        eff_data_d   = '0;
        l_data_d     = l_data_q;
        l_valid_d    = 1'b0;
        r_data_d     = r_data_q;
        r_valid_d    = 1'b0;
        timeout_d    = timeout_q;
        finish_c     = 1'b0;
        result_c     = hold_data_q;

        case (state_q)
            S_IDLE: begin
                if (grant_l_c || grant_r_c) begin
                    hold_ch_d   = grant_r_c ? CH_R : CH_L;
                    hold_data_d = grant_r_c ? bus.i_r_data : bus.i_l_data;
                    state_d     = S_ISSUE;
                    eff_valid_d = 1'b1;
                    eff_data_d  = hold_data_d;
                end
            end
            S_ISSUE: begin
                if (bus.i_eff_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    eff_valid_d = 1'b1;
                    eff_data_d  = hold_data_q;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + cnt_width'(1);
                // Effect data wins even on the final timeout cycle.
                if (bus.i_eff_valid) begin
                    finish_c = 1'b1;
                    result_c = bus.i_eff_data;
                end else if (cnt_q == cnt_last) begin
                    finish_c  = 1'b1;
                    result_c  = hold_data_q;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Route the result to the owning channel and release the pipeline.
        if (finish_c) begin
            state_d      = S_IDLE;
            last_grant_d = hold_ch_q;
            if (hold_ch_q == CH_L) begin
                l_data_d  = result_c;
                l_valid_d = 1'b1;
            end else begin
                r_data_d  = result_c;
                r_valid_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= CH_R;
            hold_ch_q    <= CH_L;
            hold_data_q  <= '0;
            cnt_q        <= '0;
            eff_valid_q  <= 1'b0;
            eff_data_q   <= '0;
            l_data_q     <= '0;
            l_valid_q    <= 1'b0;
            r_data_q     <= '0;
            r_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hold_ch_q    <= hold_ch_d;
            hold_data_q  <= hold_data_d;
            cnt_q        <= cnt_d;
            eff_valid_q  <= eff_valid_d;
            eff_data_q   <= eff_data_d;
            l_data_q     <= l_data_d;
            l_valid_q    <= l_valid_d;
            r_data_q     <= r_data_d;
            r_valid_q    <= r_valid_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.o_l_ready   = grant_l_c;
    assign bus.o_r_ready   = grant_r_c;
    assign bus.o_eff_valid = eff_valid_q;
    assign bus.o_eff_data  = eff_data_q;
    assign bus.o_l_data    = l_data_q;
    assign bus.o_l_valid   = l_valid_q;
    assign bus.o_r_data    = r_data_q;
    assign bus.o_r_valid   = r_valid_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_timeout   = timeout_q;
endmodule
